// File: rtl/text_tile_fetch_if.sv
// -----------------------------------------------------------------------------
// text_tile_fetch_if
//   Bundles the text_tile_fetch signals that are not clock or reset:
//     - scan input    : DrawX, DrawY, pix_valid
//     - host write    : wr_en, wr_addr, wr_data
//     - font_rom port : font_addr (out of the fetcher), font_data (into it)
//     - cursor        : cursor_addr
//     - aligned output: out_x, out_y, out_valid, text_on
//
//   Valid semantics: pix_valid qualifies DrawX/DrawY on the cycle it is
//   sampled, and out_valid qualifies out_x/out_y/text_on on the cycle it is
//   presented. There is no ready signal. The pipeline accepts one pixel per
//   clock, never stalls, and cannot back-pressure the VGA controller.
//
//   Modports: slave = the fetcher, master = whoever drives scan/host/font.
// -----------------------------------------------------------------------------
interface text_tile_fetch_if;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        pix_valid;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic [10:0] font_addr;
   logic [7:0]  font_data;
   logic [11:0] cursor_addr;
   logic [9:0]  out_x;
   logic [9:0]  out_y;
   logic        out_valid;
   logic        text_on;

   modport slave (
      input  DrawX, DrawY, pix_valid,
      input  wr_en, wr_addr, wr_data,
      output font_addr,
      input  font_data,
      input  cursor_addr,
      output out_x, out_y, out_valid, text_on
   );

   modport master (
      output DrawX, DrawY, pix_valid,
      output wr_en, wr_addr, wr_data,
      input  font_addr,
      output font_data,
      output cursor_addr,
      input  out_x, out_y, out_valid, text_on
   );
endinterface

// File: rtl/text_tile_fetch.sv
// -----------------------------------------------------------------------------
// text_tile_fetch
//   Text-mode pixel source feeding the colour mapper. Converts the scan
//   position into an 8x16 tile index, reads the character byte from an
//   internal buffer, fetches the glyph row from an external font_rom and
//   emits one text_on bit per pixel, aligned with delayed x/y/valid.
//
//   Ports:
//     Clk     - pixel clock, rising edge
//     Reset_n - asynchronous active-low reset (flushes the pipeline; the
//               character buffer contents are kept)
//     bus     - text_tile_fetch_if.slave (scan in, host write, font_rom,
//               cursor_addr, aligned output)
//
//   Pipeline (input sampled on edge N, output visible after edge N+3):
//     S0  register scan inputs, tile index and in_range flag
//     S1  registered character buffer read
//     S2  font_addr driven from S1, glyph bit registered
//     OUT gate with in_range/valid and register text_on, out_x/y/valid
//
//   Optional feature: define TEXT_CURSOR_EN to build a blinking underline
//   cursor at cursor_addr (glyph rows 14-15, 64-frame blink period).
//   Without it, cursor_addr is ignored and text_on is the glyph bit only.
// -----------------------------------------------------------------------------
module text_tile_fetch #(
   parameter int COLS = 80,
   parameter int ROWS = 30
) (
   input  logic             Clk,
   input  logic             Reset_n,
   text_tile_fetch_if.slave bus
);

   localparam int          DEPTH   = COLS * ROWS;
   localparam logic [11:0] DEPTH_W = 12'(DEPTH);
   localparam logic [11:0] COLS_W  = 12'(COLS);
   localparam logic [10:0] X_LIMIT = 11'(COLS * 8);
   localparam logic [10:0] Y_LIMIT = 11'(ROWS * 16);

   // Character buffer: no reset, one write port, one registered read port.
   logic [7:0] char_mem [DEPTH];

   // ---------------------------------------------------------------- S0 ---
   logic [11:0] tile_row;
   logic [11:0] tile_col;
   logic [11:0] in_tile;
   logic        in_range_c;

   assign tile_row = {6'd0, bus.DrawY[9:4]};
   assign tile_col = {5'd0, bus.DrawX[9:3]};

   // For the standard 80-column layout the row multiply is two shifts.
   always_comb begin
      if (COLS == 80) in_tile = (tile_row << 6) + (tile_row << 4) + tile_col;
      else            in_tile = tile_row * COLS_W + tile_col;
   end

   assign in_range_c = ({1'b0, bus.DrawX} < X_LIMIT) && ({1'b0, bus.DrawY} < Y_LIMIT);

   logic [9:0]  s0_x, s0_y;
   logic        s0_valid, s0_in_range;
   logic [11:0] s0_tile;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s0_x        <= '0;
         s0_y        <= '0;
         s0_valid    <= 1'b0;
         s0_in_range <= 1'b0;
         s0_tile     <= '0;
      end else begin
         s0_x        <= bus.DrawX;
         s0_y        <= bus.DrawY;
         s0_valid    <= bus.pix_valid;
         s0_in_range <= in_range_c;
         s0_tile     <= in_tile;
      end
   end

   // ------------------------------------------------------- buffer write ---
   // Writes outside the buffer are dropped. A write on the same edge as a
   // read of the same tile is not visible to that read (old byte returned).
   always_ff @(posedge Clk) begin
      if (bus.wr_en && (bus.wr_addr < DEPTH_W)) char_mem[bus.wr_addr] <= bus.wr_data;
   end

   // ---------------------------------------------------------------- S1 ---
   logic [7:0]  s1_char;
   logic [3:0]  s1_row;
   logic [2:0]  s1_col;
   logic        s1_valid, s1_in_range;
   logic [9:0]  s1_x, s1_y;
   logic [11:0] s1_tile;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_char     <= '0;
         s1_row      <= '0;
         s1_col      <= '0;
         s1_valid    <= 1'b0;
         s1_in_range <= 1'b0;
         s1_x        <= '0;
         s1_y        <= '0;
         s1_tile     <= '0;
      end else begin
         // Off-screen scan positions can form tile indices past the buffer;
         // read a blank byte instead of indexing out of range.
         s1_char     <= (s0_tile < DEPTH_W) ? char_mem[s0_tile] : 8'h00;
         s1_row      <= s0_y[3:0];
         s1_col      <= s0_x[2:0];
         s1_valid    <= s0_valid;
         s1_in_range <= s0_in_range;
         s1_x        <= s0_x;
         s1_y        <= s0_y;
         s1_tile     <= s0_tile;
      end
   end

   // ---------------------------------------------------------------- S2 ---
   logic glyph_bit;

   assign bus.font_addr = {s1_char[6:0], s1_row};
   // font_data bit 7 is the leftmost pixel; char bit 7 inverts the cell.
   assign glyph_bit = bus.font_data[3'd7 - s1_col] ^ s1_char[7];

   logic        s2_bit;
   logic        s2_valid, s2_in_range;
   logic [9:0]  s2_x, s2_y;
   logic [11:0] s2_tile;
   logic [3:0]  s2_row;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s2_bit      <= 1'b0;
         s2_valid    <= 1'b0;
         s2_in_range <= 1'b0;
         s2_x        <= '0;
         s2_y        <= '0;
         s2_tile     <= '0;
         s2_row      <= '0;
      end else begin
         s2_bit      <= glyph_bit;
         s2_valid    <= s1_valid;
         s2_in_range <= s1_in_range;
         s2_x        <= s1_x;
         s2_y        <= s1_y;
         s2_tile     <= s1_tile;
         s2_row      <= s1_row;
      end
   end

   // ------------------------------------------------------------ cursor ---
   logic cursor_hit;

`ifdef TEXT_CURSOR_EN
   logic       frame_start;
   logic [4:0] frame_cnt;
   logic       blink;

   assign frame_start = s0_valid && (s0_x == 10'd0) && (s0_y == 10'd0);

   // 32 frames per phase, so the cursor blinks with a 64-frame period.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_cnt <= '0;
         blink     <= 1'b0;
      end else if (frame_start) begin
         frame_cnt <= frame_cnt + 5'd1;
         if (frame_cnt == 5'd31) blink <= ~blink;
      end
   end

   // Underline: glyph rows 14 and 15 of the cursor tile.
   assign cursor_hit = blink && (s2_tile == bus.cursor_addr) && (s2_row[3:1] == 3'b111);
`else
   logic unused_cursor;
   assign unused_cursor = ^{bus.cursor_addr, s2_tile, s2_row};
   assign cursor_hit    = 1'b0;
`endif

   // --------------------------------------------------------------- OUT ---
   logic       text_on_q, out_valid_q;
   logic [9:0] out_x_q, out_y_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         text_on_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
      end else begin
         // Blanked outside the active area regardless of the invert bit.
         text_on_q   <= s2_valid && s2_in_range && (s2_bit || cursor_hit);
         out_valid_q <= s2_valid;
         out_x_q     <= s2_x;
         out_y_q     <= s2_y;
      end
   end

   assign bus.text_on   = text_on_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_x     = out_x_q;
   assign bus.out_y     = out_y_q;

endmodule
